// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin AR issue from a single held slot,
// R beats routed back by rid, per-requester outstanding limits and a sticky error flag.
module axi_rd_arbiter #(
   parameter int MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   output logic        data_sram_rd_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        rd_err
);

   typedef enum logic {
      GRANT_INST = 1'b0,
      GRANT_DATA = 1'b1
   } grant_e;

   localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

   logic        r_arvalid;
   logic [3:0]  r_arid;
   logic [31:0] r_araddr;
   logic [2:0]  r_arsize;
   logic [2:0]  r_inst_cnt;
   logic [2:0]  r_data_cnt;
   grant_e      r_last_grant;
   logic        r_rd_err;

   logic w_r_hs;
   logic w_inst_beat;
   logic w_data_beat;
   logic w_inst_done;
   logic w_data_done;
   logic w_stray;
   logic w_slot_free;
   logic w_inst_elig;
   logic w_data_elig;
   logic w_grant_inst;
   logic w_grant_data;

   // The SRAM side never stalls, so every beat is taken as soon as we are out of reset.
   assign w_r_hs      = rvalid && resetn;
   assign w_inst_beat = w_r_hs && (rid == 4'd0) && (r_inst_cnt != 3'd0);
   assign w_data_beat = w_r_hs && (rid == 4'd1) && (r_data_cnt != 3'd0);
   assign w_inst_done = w_inst_beat && rlast;
   assign w_data_done = w_data_beat && rlast;
   assign w_stray     = w_r_hs && !w_inst_beat && !w_data_beat;

   assign w_slot_free = !r_arvalid || arready;
   // A read retiring this cycle frees its credit early, so a full requester can still issue.
   assign w_inst_elig = inst_sram_req && ((r_inst_cnt < MAX_CNT) || w_inst_done);
   assign w_data_elig = data_sram_req && !data_sram_wr &&
                        ((r_data_cnt < MAX_CNT) || w_data_done);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_grant_inst = 1'b0;
      w_grant_data = 1'b0;
      if (resetn && w_slot_free) begin
         if (w_inst_elig && w_data_elig) begin
            w_grant_data = (r_last_grant == GRANT_INST);
            w_grant_inst = (r_last_grant == GRANT_DATA);
         end else begin
            w_grant_inst = w_inst_elig;
            w_grant_data = w_data_elig;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_arvalid    <= 1'b0;
         r_arid       <= 4'd0;
         r_araddr     <= 32'd0;
         r_arsize     <= 3'd0;
         r_last_grant <= GRANT_INST;
      end else if (w_grant_inst) begin
         r_arvalid    <= 1'b1;
         r_arid       <= 4'd0;
         r_araddr     <= inst_sram_addr;
         r_arsize     <= {1'b0, inst_sram_size};
         r_last_grant <= GRANT_INST;
      end else if (w_grant_data) begin
         r_arvalid    <= 1'b1;
         r_arid       <= 4'd1;
         r_araddr     <= data_sram_addr;
         r_arsize     <= {1'b0, data_sram_size};
         r_last_grant <= GRANT_DATA;
      end else if (arready) begin
         r_arvalid    <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_inst_cnt <= 3'd0;
         r_data_cnt <= 3'd0;
         r_rd_err   <= 1'b0;
      end else begin
         case ({w_grant_inst, w_inst_done})
            2'b10:   r_inst_cnt <= r_inst_cnt + 3'd1;
            2'b01:   r_inst_cnt <= r_inst_cnt - 3'd1;
            default: r_inst_cnt <= r_inst_cnt;
         endcase
         case ({w_grant_data, w_data_done})
            2'b10:   r_data_cnt <= r_data_cnt + 3'd1;
            2'b01:   r_data_cnt <= r_data_cnt - 3'd1;
            default: r_data_cnt <= r_data_cnt;
         endcase
         if (w_stray || (w_r_hs && (rresp != 2'b00))) begin
            r_rd_err <= 1'b1;
         end
      end
   end

   assign inst_sram_addr_ok    = w_grant_inst;
   assign data_sram_rd_addr_ok = w_grant_data;
   assign inst_sram_data_ok    = w_inst_beat;
   assign data_sram_data_ok    = w_data_beat;
   assign inst_sram_rdata      = rdata;
   assign data_sram_rdata      = rdata;

   assign arvalid = r_arvalid;
   assign arid    = r_arid;
   assign araddr  = r_araddr;
   assign arsize  = r_arsize;
   assign arlen   = 8'd0;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign rready  = resetn;
   assign rd_err  = r_rd_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed cycle table, hand-written corner sequences,
// then random traffic against a queue-based reference model.
module tb_axi_rd_arbiter;

   localparam int MAX = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_req;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic        data_sram_rd_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        rd_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.MAX_OUTST(MAX)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
      .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_rd_addr_ok(data_sram_rd_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready), .rd_err(rd_err)
   );

   typedef struct packed {
      logic        ireq;
      logic        dreq;
      logic        dwr;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic        arr;
      logic        rv;
      logic [3:0]  rid_v;
      logic [31:0] rd;
      logic        e_iok;
      logic        e_dok;
      logic        e_idok;
      logic        e_ddok;
      logic        e_av;
      logic [31:0] e_aa;
      logic [3:0]  e_id;
   } vec_t;

   function automatic vec_t row(logic ireq, logic dreq, logic dwr, logic [31:0] iaddr,
                                logic [31:0] daddr, logic arr, logic rv, logic [3:0] rid_v,
                                logic [31:0] rd, logic e_iok, logic e_dok, logic e_idok,
                                logic e_ddok, logic e_av, logic [31:0] e_aa, logic [3:0] e_id);
      vec_t v;
      v = '{ireq, dreq, dwr, iaddr, daddr, arr, rv, rid_v, rd,
            e_iok, e_dok, e_idok, e_ddok, e_av, e_aa, e_id};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_sram_req  = 1'b0;
      inst_sram_size = 2'd2;
      inst_sram_addr = 32'd0;
      data_sram_req  = 1'b0;
      data_sram_wr   = 1'b0;
      data_sram_size = 2'd2;
      data_sram_addr = 32'd0;
      arready        = 1'b1;
      rvalid         = 1'b0;
      rid            = 4'd0;
      rdata          = 32'd0;
      rresp          = 2'b00;
      rlast          = 1'b1;
   endtask

   // Reset for one edge with live requests and a beat present; everything must read as cleared.
   task automatic do_reset();
      idle();
      inst_sram_req  = 1'b1;
      data_sram_req  = 1'b1;
      inst_sram_addr = 32'hDEAD_0000;
      data_sram_addr = 32'hDEAD_0004;
      rvalid         = 1'b1;
      resetn         = 1'b0;
      tick();
      check("rst_arvalid", arvalid, 0);
      check("rst_araddr", araddr, 0);
      check("rst_arid", arid, 0);
      check("rst_arsize", arsize, 0);
      check("rst_rd_err", rd_err, 0);
      check("rst_rready", rready, 0);
      check("rst_inst_addr_ok", inst_sram_addr_ok, 0);
      check("rst_data_addr_ok", data_sram_rd_addr_ok, 0);
      check("rst_inst_data_ok", inst_sram_data_ok, 0);
      check("rst_data_data_ok", data_sram_data_ok, 0);
      idle();
      resetn = 1'b1;
   endtask

   // Reference model: in-flight reads per requester as queues, AR slot as plain fields.
   logic [31:0] m_iq[$];
   logic [31:0] m_dq[$];
   bit          m_slot_valid;
   logic [31:0] m_slot_addr;
   logic [3:0]  m_slot_id;
   logic [1:0]  m_slot_size;
   bit          m_last_data;
   bit          m_err;

   task automatic model_clear();
      m_iq.delete();
      m_dq.delete();
      m_slot_valid = 0;
      m_slot_addr  = 32'd0;
      m_slot_id    = 4'd0;
      m_slot_size  = 2'd0;
      m_last_data  = 0;
      m_err        = 0;
   endtask

   task automatic model_step();
      bit hit_i, hit_d, free, ie, de, acc_i, acc_d;
      hit_i = resetn && rvalid && rid == 4'd0 && m_iq.size() > 0;
      hit_d = resetn && rvalid && rid == 4'd1 && m_dq.size() > 0;
      free  = !m_slot_valid || arready;
      ie    = inst_sram_req && (m_iq.size() < MAX || (hit_i && rlast));
      de    = data_sram_req && !data_sram_wr && (m_dq.size() < MAX || (hit_d && rlast));
      acc_i = resetn && free && ie && !(de && !m_last_data);
      acc_d = resetn && free && de && !acc_i;

      check("m_inst_addr_ok", inst_sram_addr_ok, acc_i);
      check("m_data_addr_ok", data_sram_rd_addr_ok, acc_d);
      check("m_inst_data_ok", inst_sram_data_ok, hit_i);
      check("m_data_data_ok", data_sram_data_ok, hit_d);
      check("m_rready", rready, resetn);
      check("m_arvalid", arvalid, m_slot_valid);
      check("m_rd_err", rd_err, m_err);
      if (m_slot_valid) begin
         check("m_araddr", araddr, m_slot_addr);
         check("m_arid", arid, m_slot_id);
         check("m_arsize", arsize, {1'b0, m_slot_size});
      end
      if (hit_i) check("m_inst_rdata", inst_sram_rdata, rdata);
      if (hit_d) check("m_data_rdata", data_sram_rdata, rdata);

      if (!resetn) begin
         model_clear();
      end else begin
         if (hit_i && rlast) void'(m_iq.pop_front());
         if (hit_d && rlast) void'(m_dq.pop_front());
         if (m_slot_valid && arready) m_slot_valid = 0;
         if (acc_i) begin
            m_iq.push_back(inst_sram_addr);
            m_slot_valid = 1; m_slot_addr = inst_sram_addr;
            m_slot_id = 4'd0; m_slot_size = inst_sram_size; m_last_data = 0;
         end else if (acc_d) begin
            m_dq.push_back(data_sram_addr);
            m_slot_valid = 1; m_slot_addr = data_sram_addr;
            m_slot_id = 4'd1; m_slot_size = data_sram_size; m_last_data = 1;
         end
         if (rvalid && (!(hit_i || hit_d) || rresp != 2'b00)) m_err = 1;
      end
   endtask

   vec_t vecs[20];

   initial begin
      vecs[0]  = row(1, 0, 0, 32'hBFC0_0000, 0, 1, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0);
      vecs[1]  = row(0, 0, 0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0, 1, 32'hBFC0_0000, 0);
      vecs[2]  = row(0, 0, 0, 0, 0,            1, 1, 0, 32'h3C1D_0001, 0, 0, 1, 0, 0, 0, 0);
      vecs[3]  = row(1, 1, 0, 32'h100, 32'h200, 1, 0, 0, 0,           0, 1, 0, 0, 0, 0, 0);
      vecs[4]  = row(1, 1, 0, 32'h100, 32'h200, 1, 0, 0, 0,           1, 0, 0, 0, 1, 32'h200, 1);
      vecs[5]  = row(1, 1, 0, 32'h100, 32'h200, 1, 0, 0, 0,           0, 1, 0, 0, 1, 32'h100, 0);
      vecs[6]  = row(1, 1, 0, 32'h100, 32'h200, 1, 0, 0, 0,           1, 0, 0, 0, 1, 32'h200, 1);
      vecs[7]  = row(1, 1, 0, 32'h100, 32'h200, 1, 0, 0, 0,           0, 0, 0, 0, 1, 32'h100, 0);
      vecs[8]  = row(1, 1, 0, 32'h100, 32'h200, 1, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0);
      vecs[9]  = row(0, 0, 0, 0, 0,            1, 1, 1, 32'hD000_0001, 0, 0, 0, 1, 0, 0, 0);
      vecs[10] = row(0, 0, 0, 0, 0,            1, 1, 0, 32'h1000_0001, 0, 0, 1, 0, 0, 0, 0);
      vecs[11] = row(1, 0, 0, 32'h300, 0,      1, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0);
      vecs[12] = row(1, 0, 0, 32'h304, 0,      1, 1, 0, 32'h1000_0002, 1, 0, 1, 0, 1, 32'h300, 0);
      vecs[13] = row(1, 1, 0, 32'h308, 32'h400, 1, 0, 0, 0,           0, 1, 0, 0, 1, 32'h304, 0);
      vecs[14] = row(0, 0, 0, 0, 0,            1, 0, 0, 0,            0, 0, 0, 0, 1, 32'h400, 1);
      vecs[15] = row(0, 0, 0, 0, 0,            1, 1, 0, 32'h1000_0003, 0, 0, 1, 0, 0, 0, 0);
      vecs[16] = row(0, 0, 0, 0, 0,            1, 1, 0, 32'h1000_0004, 0, 0, 1, 0, 0, 0, 0);
      vecs[17] = row(0, 0, 0, 0, 0,            1, 1, 1, 32'hD000_0002, 0, 0, 0, 1, 0, 0, 0);
      vecs[18] = row(0, 0, 0, 0, 0,            1, 1, 1, 32'hD000_0003, 0, 0, 0, 1, 0, 0, 0);
      vecs[19] = row(0, 1, 1, 0, 32'h500,      1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0);

      idle();
      resetn = 1'b0;
      tick();
      do_reset();

      check("const_arlen", arlen, 0);
      check("const_arburst", arburst, 2'b01);
      check("const_arlock", arlock, 0);
      check("const_arcache", arcache, 0);
      check("const_arprot", arprot, 0);

      for (int i = 0; i < 20; i++) begin
         inst_sram_req  = vecs[i].ireq;
         inst_sram_addr = vecs[i].iaddr;
         data_sram_req  = vecs[i].dreq;
         data_sram_wr   = vecs[i].dwr;
         data_sram_addr = vecs[i].daddr;
         arready        = vecs[i].arr;
         rvalid         = vecs[i].rv;
         rid            = vecs[i].rid_v;
         rdata          = vecs[i].rd;
         #1;
         check($sformatf("vec%0d_inst_addr_ok", i), inst_sram_addr_ok, vecs[i].e_iok);
         check($sformatf("vec%0d_data_addr_ok", i), data_sram_rd_addr_ok, vecs[i].e_dok);
         check($sformatf("vec%0d_inst_data_ok", i), inst_sram_data_ok, vecs[i].e_idok);
         check($sformatf("vec%0d_data_data_ok", i), data_sram_data_ok, vecs[i].e_ddok);
         check($sformatf("vec%0d_arvalid", i), arvalid, vecs[i].e_av);
         check($sformatf("vec%0d_rd_err", i), rd_err, 0);
         if (vecs[i].e_av) begin
            check($sformatf("vec%0d_araddr", i), araddr, vecs[i].e_aa);
            check($sformatf("vec%0d_arid", i), arid, vecs[i].e_id);
            check($sformatf("vec%0d_arsize", i), arsize, 3'd2);
         end
         if (vecs[i].e_idok) check($sformatf("vec%0d_inst_rdata", i), inst_sram_rdata, vecs[i].rd);
         if (vecs[i].e_ddok) check($sformatf("vec%0d_data_rdata", i), data_sram_rdata, vecs[i].rd);
         tick();
      end
      idle();

      // AR backpressure: slot must hold for 5 stalled cycles, then handshake and re-accept together.
      inst_sram_req = 1'b1; inst_sram_addr = 32'hA000; inst_sram_size = 2'd1; arready = 1'b0;
      #1;
      check("bp_first_accept", inst_sram_addr_ok, 1);
      tick();
      inst_sram_addr = 32'hA004;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_arvalid_hold", arvalid, 1);
         check("bp_araddr_hold", araddr, 32'hA000);
         check("bp_arsize_hold", arsize, 3'd1);
         check("bp_addr_ok_low", inst_sram_addr_ok, 0);
         tick();
      end
      arready = 1'b1;
      #1;
      check("bp_release_accept", inst_sram_addr_ok, 1);
      check("bp_release_araddr", araddr, 32'hA000);
      tick();
      idle();
      #1;
      check("bp_next_arvalid", arvalid, 1);
      check("bp_next_araddr", araddr, 32'hA004);
      tick();

      // Unknown rid is dropped and flags an error.
      rvalid = 1'b1; rid = 4'd3; rdata = 32'h5555_5555;
      #1;
      check("stray_id_inst_ok", inst_sram_data_ok, 0);
      check("stray_id_data_ok", data_sram_data_ok, 0);
      tick();
      idle();
      #1;
      check("stray_id_rd_err", rd_err, 1);

      // Error response on an owned beat is delivered but still flags an error.
      do_reset();
      inst_sram_req = 1'b1; inst_sram_addr = 32'hB000;
      #1;
      check("resp_issue_ok", inst_sram_addr_ok, 1);
      tick();
      idle();
      tick();
      rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_F00D; rresp = 2'b10;
      #1;
      check("resp_data_ok", inst_sram_data_ok, 1);
      check("resp_rdata", inst_sram_rdata, 32'hCAFE_F00D);
      check("resp_err_before", rd_err, 0);
      tick();
      idle();
      #1;
      check("resp_rd_err", rd_err, 1);

      // Reset with a held AR and one outstanding read: both are forgotten.
      do_reset();
      inst_sram_req = 1'b1; inst_sram_addr = 32'hC000; arready = 1'b0;
      #1;
      check("midrst_issue_ok", inst_sram_addr_ok, 1);
      tick();
      idle();
      arready = 1'b0;
      #1;
      check("midrst_arvalid_pre", arvalid, 1);
      do_reset();
      rvalid = 1'b1; rid = 4'd0; rdata = 32'h7777_0000;
      #1;
      check("midrst_no_data_ok", inst_sram_data_ok, 0);
      tick();
      idle();
      #1;
      check("midrst_rd_err", rd_err, 1);

      // Random traffic against the reference model.
      do_reset();
      model_clear();
      for (int n = 0; n < 3000; n++) begin
         int r;
         resetn         = ($urandom % 150) != 0;
         inst_sram_req  = ($urandom % 3) != 0;
         inst_sram_size = 2'($urandom % 4);
         inst_sram_addr = $urandom;
         data_sram_req  = ($urandom % 3) != 0;
         data_sram_wr   = ($urandom % 4) == 0;
         data_sram_size = 2'($urandom % 4);
         data_sram_addr = $urandom;
         arready        = ($urandom % 4) != 0;
         rvalid         = ($urandom % 2) != 0;
         r              = int'($urandom % 16);
         rid            = (r < 7) ? 4'd0 : (r < 14) ? 4'd1 : (r == 14) ? 4'd3 : 4'd2;
         rdata          = $urandom;
         rresp          = (($urandom % 40) == 0) ? 2'b10 : 2'b00;
         rlast          = 1'b1;
         #1;
         model_step();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
